// File: rtl/mc_ctl_unit.sv
// Multicycle RV32I control FSM; 2-5 cycles per instruction plus memory waits (CTL_UTYPE_EN adds LUI/AUIPC).
// Stalls in FETCH/MEMREAD/MEMWRITE until mem_ready; bus_err after MEM_TIMEOUT wait cycles (0 = wait forever).
module mc_ctl_unit #(
    parameter int ALUCTL_W    = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          op,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                adrsrc,
    output logic                irwrite,
    output logic                pcwrite,
    output logic                memwrite,
    output logic                regwrite,
    output logic [1:0]          resultsrc,
    output logic [1:0]          alusrca,
    output logic [1:0]          alusrcb,
    output logic [2:0]          immsrc,
    output logic [ALUCTL_W-1:0] alucontrol,
    output logic                illegal_instr,
    output logic                bus_err
);

`ifdef CTL_UTYPE_EN
    localparam bit UTYPE_EN = 1'b1;
`else
    localparam bit UTYPE_EN = 1'b0;
`endif

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_PASSB = 4'd10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_ERR, S_EXECU
    } state_t;

    state_t           state, state_nxt, dec_nxt;
    logic             dec_legal;
    logic [CNT_W-1:0] wait_cnt;
    logic             req_state, timeout;
    logic [3:0]       funct_op, alu_op;
    logic             unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        unique case (funct3)
            3'b000:  funct_op = (op[5] & funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  funct_op = ALU_SLL;
            3'b010:  funct_op = ALU_SLT;
            3'b011:  funct_op = ALU_SLTU;
            3'b100:  funct_op = ALU_XOR;
            3'b101:  funct_op = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  funct_op = ALU_OR;
            default: funct_op = ALU_AND;
        endcase
    end

    always_comb begin
        dec_nxt   = S_FETCH;
        dec_legal = 1'b1;
        case (op)
            OP_LOAD, OP_STORE: dec_nxt = S_MEMADR;
            OP_R:              dec_nxt = S_EXECR;
            OP_I:              dec_nxt = S_EXECI;
            OP_BR:             dec_nxt = S_BRANCH;
            OP_JAL:            dec_nxt = S_JAL;
            OP_LUI, OP_AUIPC: begin
                if (UTYPE_EN) dec_nxt = S_EXECU;
                else          dec_legal = 1'b0;
            end
            default:           dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE:         immsrc = 3'b001;
            OP_BR:            immsrc = 3'b010;
            OP_JAL:           immsrc = 3'b011;
            OP_LUI, OP_AUIPC: immsrc = UTYPE_EN ? 3'b100 : 3'b000;
            default:          immsrc = 3'b000;
        endcase
    end

    // Threshold cycle with mem_ready high completes normally: ready wins over timeout.
    assign req_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign timeout   = (MEM_TIMEOUT > 0) && req_state && !mem_ready &&
                       (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (req_state && !mem_ready && (wait_cnt != '1))
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:    state_nxt = mem_ready ? S_DECODE : (timeout ? S_ERR : S_FETCH);
            S_DECODE:   state_nxt = dec_nxt;
            S_MEMADR:   state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_nxt = mem_ready ? S_MEMWB : (timeout ? S_ERR : S_MEMREAD);
            S_MEMWRITE: state_nxt = mem_ready ? S_FETCH : (timeout ? S_ERR : S_MEMWRITE);
            S_EXECR, S_EXECI, S_JAL, S_EXECU: state_nxt = S_ALUWB;
            default:    state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req       = 1'b0;
        adrsrc        = 1'b0;
        irwrite       = 1'b0;
        pcwrite       = 1'b0;
        memwrite      = 1'b0;
        regwrite      = 1'b0;
        resultsrc     = 2'b00;
        alusrca       = 2'b00;
        alusrcb       = 2'b00;
        alu_op        = ALU_ADD;
        illegal_instr = 1'b0;
        bus_err       = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite   = mem_ready;
                pcwrite   = mem_ready;
            end
            S_DECODE: begin
                alusrca       = 2'b01;
                alusrcb       = 2'b01;
                illegal_instr = !dec_legal;
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adrsrc  = 1'b1;
            end
            S_MEMWB: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                adrsrc   = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECR: begin
                alusrca = 2'b10;
                alu_op  = funct_op;
            end
            S_EXECI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                alu_op  = funct_op;
            end
            S_ALUWB: regwrite = 1'b1;
            S_BRANCH: begin
                alusrca = 2'b10;
                alu_op  = ALU_SUB;
                pcwrite = ((funct3 == 3'b000) & zero) | ((funct3 == 3'b001) & !zero);
            end
            S_JAL: begin
                alusrca = 2'b01;
                alusrcb = 2'b10;
                pcwrite = 1'b1;
            end
            S_EXECU: begin
                alusrcb = 2'b01;
                if (op[5]) begin
                    alu_op = ALU_PASSB;
                end else begin
                    alusrca = 2'b01;
                end
            end
            S_ERR:   bus_err = 1'b1;
            default: ;
        endcase
        if (rst) begin
            mem_req       = 1'b0;
            irwrite       = 1'b0;
            pcwrite       = 1'b0;
            memwrite      = 1'b0;
            regwrite      = 1'b0;
            illegal_instr = 1'b0;
            bus_err       = 1'b0;
        end
    end

    assign alucontrol = ALUCTL_W'(alu_op);

endmodule

// File: tb/tb_mc_ctl_unit.sv
// Cycle-by-cycle directed vectors for mc_ctl_unit (MEM_TIMEOUT=4); each record is one clock of inputs and outputs.
module tb_mc_ctl_unit;
    logic       clk = 1'b0;
    logic       rst, zero, mem_ready;
    logic [6:0] op, funct7;
    logic [2:0] funct3;
    logic       mem_req, adrsrc, irwrite, pcwrite, memwrite, regwrite, illegal_instr, bus_err;
    logic [1:0] resultsrc, alusrca, alusrcb;
    logic [2:0] immsrc;
    logic [3:0] alucontrol;
    logic [20:0] act;

    always #5 clk = ~clk;

    mc_ctl_unit #(.ALUCTL_W(4), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .adrsrc(adrsrc), .irwrite(irwrite),
        .pcwrite(pcwrite), .memwrite(memwrite), .regwrite(regwrite), .resultsrc(resultsrc),
        .alusrca(alusrca), .alusrcb(alusrcb), .immsrc(immsrc), .alucontrol(alucontrol),
        .illegal_instr(illegal_instr), .bus_err(bus_err)
    );

    assign act = {mem_req, adrsrc, irwrite, pcwrite, memwrite, regwrite, resultsrc,
                  alusrca, alusrcb, immsrc, alucontrol, illegal_instr, bus_err};

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, SYS = 7'b1110011, LUI = 7'b0110111;
    localparam logic [6:0] F7A = 7'b0000000, F7S = 7'b0100000;
`ifdef CTL_UTYPE_EN
    localparam logic [2:0] U_IMM = 3'b100;
`else
    localparam logic [2:0] U_IMM = 3'b000;
`endif

    typedef struct {
        string      name;
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       zero;
        logic       rdy;
        logic [20:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [1:0] sb;
        logic [3:0] alu;
    } alu_case_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic logic [20:0] ex(input logic mreq, adr, irw, pcw, mw, rw,
                                       input logic [1:0] rs, sa, sb, input logic [2:0] imm,
                                       input logic [3:0] alu, input logic ill, be);
        return {mreq, adr, irw, pcw, mw, rw, rs, sa, sb, imm, alu, ill, be};
    endfunction

    function automatic logic [20:0] fx(input logic [2:0] imm);
        return ex(1, 0, 1, 1, 0, 0, 2'b10, 2'b00, 2'b10, imm, 4'd0, 0, 0);
    endfunction

    function automatic logic [20:0] dx(input logic [2:0] imm);
        return ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 4'd0, 0, 0);
    endfunction

    function automatic logic [20:0] wbx(input logic [2:0] imm);
        return ex(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 4'd0, 0, 0);
    endfunction

    function automatic vec_t mk(input string nm, input logic r, input logic [6:0] o,
                                input logic [2:0] f3, input logic [6:0] f7, input logic z,
                                input logic rdy, input logic [20:0] e);
        vec_t v;
        v.name = nm; v.rst = r; v.op = o; v.f3 = f3; v.f7 = f7;
        v.zero = z; v.rdy = rdy; v.exp = e;
        return v;
    endfunction

    function automatic void add(input string nm, input logic r, input logic [6:0] o,
                                input logic [2:0] f3, input logic [6:0] f7, input logic z,
                                input logic rdy, input logic [20:0] e);
        tbl.push_back(mk(nm, r, o, f3, f7, z, rdy, e));
    endfunction

    function automatic void add_alu(input alu_case_t c);
        add({c.name, "_fetch"},  0, c.op, c.f3, c.f7, 0, 1, fx(3'b000));
        add({c.name, "_decode"}, 0, c.op, c.f3, c.f7, 0, 1, dx(3'b000));
        add({c.name, "_exec"},   0, c.op, c.f3, c.f7, 0, 1,
            ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, c.sb, 3'b000, c.alu, 0, 0));
        add({c.name, "_wb"},     0, c.op, c.f3, c.f7, 0, 1, wbx(3'b000));
    endfunction

    task automatic step(input vec_t v);
        @(negedge clk);
        rst = v.rst; op = v.op; funct3 = v.f3; funct7 = v.f7; zero = v.zero; mem_ready = v.rdy;
        #1;
        n_vec++;
        if (act !== v.exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", v.name, act, v.exp);
        end
    endtask

    alu_case_t alu_cases[14] = '{
        '{"add",  R, 3'b000, F7A, 2'b00, 4'd0}, '{"sub",  R, 3'b000, F7S, 2'b00, 4'd1},
        '{"sll",  R, 3'b001, F7A, 2'b00, 4'd7}, '{"slt",  R, 3'b010, F7A, 2'b00, 4'd5},
        '{"sltu", R, 3'b011, F7A, 2'b00, 4'd6}, '{"xor",  R, 3'b100, F7A, 2'b00, 4'd4},
        '{"srl",  R, 3'b101, F7A, 2'b00, 4'd8}, '{"sra",  R, 3'b101, F7S, 2'b00, 4'd9},
        '{"or",   R, 3'b110, F7A, 2'b00, 4'd3}, '{"and",  R, 3'b111, F7A, 2'b00, 4'd2},
        '{"addi_f7", I, 3'b000, F7S, 2'b01, 4'd0}, '{"srai", I, 3'b101, F7S, 2'b01, 4'd9},
        '{"srli", I, 3'b101, F7A, 2'b01, 4'd8}, '{"andi", I, 3'b111, F7A, 2'b01, 4'd2}
    };

    initial begin
        rst = 1'b1; op = R; funct3 = 3'b000; funct7 = F7A; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);

        // reset held: FETCH selects visible, all strobes forced low
        add("reset_hold", 1, R, 3'b000, F7A, 0, 1, ex(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 4'd0, 0, 0));
        foreach (alu_cases[k]) add_alu(alu_cases[k]);

        // lw: 3 wait cycles, ready arrives exactly at the timeout threshold
        add("lw_fetch",  0, LD, 3'b010, F7A, 0, 1, fx(3'b000));
        add("lw_decode", 0, LD, 3'b010, F7A, 0, 1, dx(3'b000));
        add("lw_memadr", 0, LD, 3'b010, F7A, 0, 1, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 4'd0, 0, 0));
        for (int w = 0; w < 4; w++)
            add($sformatf("lw_memread%0d", w), 0, LD, 3'b010, F7A, 0, (w == 3),
                ex(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 0, 0));
        add("lw_memwb",  0, LD, 3'b010, F7A, 0, 1, ex(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 4'd0, 0, 0));

        add("sw_fetch",  0, ST, 3'b010, F7A, 0, 1, fx(3'b001));
        add("sw_decode", 0, ST, 3'b010, F7A, 0, 1, dx(3'b001));
        add("sw_memadr", 0, ST, 3'b010, F7A, 0, 1, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 4'd0, 0, 0));
        add("sw_memwr",  0, ST, 3'b010, F7A, 0, 1, ex(1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b001, 4'd0, 0, 0));

        // branches: {f3, zero, expected pcwrite}
        for (int b = 0; b < 4; b++) begin
            logic [2:0] f3;
            logic       z, tk;
            f3 = (b == 3) ? 3'b100 : ((b == 0) ? 3'b000 : 3'b001);
            z  = (b != 2);
            tk = (b == 0) || (b == 2);
            add($sformatf("br%0d_fetch", b),  0, BR, f3, F7A, z, 1, fx(3'b010));
            add($sformatf("br%0d_decode", b), 0, BR, f3, F7A, z, 1, dx(3'b010));
            add($sformatf("br%0d_branch", b), 0, BR, f3, F7A, z, 1,
                ex(0, 0, 0, tk, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 4'd1, 0, 0));
        end

        add("jal_fetch",  0, JL, 3'b000, F7A, 0, 1, fx(3'b011));
        add("jal_decode", 0, JL, 3'b000, F7A, 0, 1, dx(3'b011));
        add("jal_jal",    0, JL, 3'b000, F7A, 0, 1, ex(0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 2'b10, 3'b011, 4'd0, 0, 0));
        add("jal_wb",     0, JL, 3'b000, F7A, 0, 1, wbx(3'b011));

        add("sys_fetch",  0, SYS, 3'b000, F7A, 0, 1, fx(3'b000));
        add("sys_decode", 0, SYS, 3'b000, F7A, 0, 1, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 4'd0, 1, 0));

        add("lui_fetch", 0, LUI, 3'b000, F7A, 0, 1, fx(U_IMM));
`ifdef CTL_UTYPE_EN
        add("lui_decode", 0, LUI, 3'b000, F7A, 0, 1, dx(U_IMM));
        add("lui_execu",  0, LUI, 3'b000, F7A, 0, 1, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 3'b100, 4'd10, 0, 0));
        add("lui_wb",     0, LUI, 3'b000, F7A, 0, 1, wbx(U_IMM));
`else
        add("lui_decode", 0, LUI, 3'b000, F7A, 0, 1, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 4'd0, 1, 0));
`endif

        foreach (tbl[i]) step(tbl[i]);

        // fetch timeout: 4 unanswered requests, one bus_err, refetch without pcwrite
        for (int w = 0; w < 4; w++)
            step(mk($sformatf("fto_wait%0d", w), 0, R, 3'b000, F7A, 0, 0,
                    ex(1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 4'd0, 0, 0)));
        step(mk("fto_err", 0, R, 3'b000, F7A, 0, 0, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 0, 1)));
        step(mk("fto_refetch_wait", 0, R, 3'b000, F7A, 0, 0, ex(1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 4'd0, 0, 0)));
        step(mk("fto_refetch", 0, R, 3'b000, F7A, 0, 1, fx(3'b000)));
        step(mk("fto_decode",  0, R, 3'b000, F7A, 0, 1, dx(3'b000)));
        step(mk("fto_exec",    0, R, 3'b000, F7A, 0, 1, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 4'd0, 0, 0)));
        step(mk("fto_wb",      0, R, 3'b000, F7A, 0, 1, wbx(3'b000)));

        // reset during a stalled store: strobes drop in the reset cycle, FETCH follows
        step(mk("rsw_fetch",  0, ST, 3'b010, F7A, 0, 1, fx(3'b001)));
        step(mk("rsw_decode", 0, ST, 3'b010, F7A, 0, 1, dx(3'b001)));
        step(mk("rsw_memadr", 0, ST, 3'b010, F7A, 0, 1, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 4'd0, 0, 0)));
        step(mk("rsw_wait",   0, ST, 3'b010, F7A, 0, 0, ex(1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b001, 4'd0, 0, 0)));
        step(mk("rsw_rst",    1, ST, 3'b010, F7A, 0, 0, ex(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b001, 4'd0, 0, 0)));
        step(mk("rsw_fetch2", 0, ST, 3'b010, F7A, 0, 1, fx(3'b001)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
